// File: rtl/dpram_port_arbiter_pkg.sv
// Shared definitions for the dual-port RAM peripheral-side arbiter.
//   - state_t     : arbiter FSM state encoding (IDLE / ACCESS / DONE)
//   - DEFAULT_AW  : default RAM address width (256-word RAM)
//   - DEFAULT_DW  : default RAM data width
//   - wrap_inc()  : increment an index modulo n (round-robin pointer advance)
package dpram_port_arbiter_pkg;

    localparam int DEFAULT_AW = 8;
    localparam int DEFAULT_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Peripheral-side request bus shared by NREQ requesters and the arbiter.
//   req   : per-requester request, held until ack
//   we    : per-requester direction (1 = write, 0 = read)
//   addr  : flattened addresses, requester i at [i*AW +: AW]
//   wdata : flattened write data, requester i at [i*DW +: DW]
//   ack   : one-hot, one-cycle completion pulse
//   rdata : read data, valid in the ack cycle of a read
//   busy  : arbiter is in the middle of a transaction
// Modports: master = requester side, slave = arbiter side.
interface dpram_port_arbiter_if
    import dpram_port_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = DEFAULT_AW,
    parameter int DW   = DEFAULT_DW
);

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, busy
    );

endinterface

// File: rtl/dpram_port_arbiter_rr_priority_pick.sv
// Combinational round-robin picker.
//   req    : NREQ-bit request vector
//   rr_ptr : index of the requester with the highest priority
//   grant  : first requester with req set, scanning upward from rr_ptr
//            modulo NREQ
//   valid  : at least one request is set (grant is 0 otherwise)
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   grant,
    output logic            valid
);

    // Scan from the farthest candidate back toward rr_ptr so the last hit,
    // which is the closest one at or after rr_ptr, is the one that sticks.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                grant = IW'((int'(rr_ptr) + k) % NREQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing the peripheral-side port of the 256x16
// dual-port RAM between NREQ requesters. Each transaction is a single-word
// read or write: IDLE picks a requester and registers the RAM strobes,
// ACCESS holds ram_rd/ram_wr for one cycle (the RAM acts on the falling
// edge inside it), DONE pulses ack for one cycle.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : requester bus (slave side)
//   ram_addr : RAM port-2 address
//   ram_din  : RAM port-2 write data
//   ram_rd   : RAM port-2 read strobe
//   ram_wr   : RAM port-2 write strobe
//   ram_dout : RAM port-2 read data
module dpram_port_arbiter
    import dpram_port_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = DEFAULT_AW,
    parameter int DW   = DEFAULT_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    dpram_port_arbiter_if.slave        bus,
    output logic [AW-1:0]              ram_addr,
    output logic [DW-1:0]              ram_din,
    output logic                       ram_rd,
    output logic                       ram_wr,
    input  logic [DW-1:0]              ram_dout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]   gnt_idx, gnt_idx_nxt;
    logic [NREQ-1:0] ack_q, ack_nxt;
    logic [DW-1:0]   rdata_q, rdata_nxt;
    logic [AW-1:0]   ram_addr_nxt;
    logic [DW-1:0]   ram_din_nxt;
    logic            ram_rd_nxt, ram_wr_nxt;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;

    rr_priority_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .grant  (pick_idx),
        .valid  (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_rd   <= 1'b0;
            ram_wr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            gnt_idx  <= gnt_idx_nxt;
            ack_q    <= ack_nxt;
            rdata_q  <= rdata_nxt;
            ram_addr <= ram_addr_nxt;
            ram_din  <= ram_din_nxt;
            ram_rd   <= ram_rd_nxt;
            ram_wr   <= ram_wr_nxt;
        end
    end

    // Strobes default low so they can only be high in the cycle after IDLE
    // registers them, i.e. throughout ACCESS and nowhere else.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        gnt_idx_nxt  = gnt_idx;
        ack_nxt      = '0;
        rdata_nxt    = rdata_q;
        ram_addr_nxt = ram_addr;
        ram_din_nxt  = ram_din;
        ram_rd_nxt   = 1'b0;
        ram_wr_nxt   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_idx_nxt  = pick_idx;
                    ram_addr_nxt = bus.addr[int'(pick_idx) * AW +: AW];
                    ram_din_nxt  = bus.wdata[int'(pick_idx) * DW +: DW];
                    ram_rd_nxt   = ~bus.we[pick_idx];
                    ram_wr_nxt   = bus.we[pick_idx];
                    state_nxt    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (ram_rd) begin
                    rdata_nxt = ram_dout;
                end
                ack_nxt[gnt_idx] = 1'b1;
                rr_ptr_nxt       = IW'(wrap_inc(int'(gnt_idx), NREQ));
                state_nxt        = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: a behavioural RAM on the falling edge, a
// transaction-level reference model of the arbiter, directed scenarios and
// a randomized phase with occasional resets.
module tb_dpram_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dpram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_rd;
    logic          ram_wr;

    dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_rd   (ram_rd),
        .ram_wr   (ram_wr),
        .ram_dout (ram_dout)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return (a == 16) ? 16'hBEEF : {8'(a) ^ 8'h5A, 8'(a)};
    endfunction

    // Behavioural RAM port 2, acting on the falling edge
    logic          ram_init;
    logic [DW-1:0] ram_mem [0:255];
    always @(negedge clk) begin
        if (ram_init) begin
            for (int a = 0; a < 256; a++) ram_mem[a] <= init_word(a);
        end else begin
            if (ram_wr) ram_mem[ram_addr] <= ram_din;
            if (ram_rd) ram_dout <= ram_mem[ram_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0]   ref_mem [0:255];
    int              cyc;
    int              ptr;
    int              last_grant;
    int              cur_g;
    logic            cur_we;
    logic [DW-1:0]   cur_rdv;
    logic [DW-1:0]   exp_rdata;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_din;
    logic            exp_rd, exp_wr, exp_busy;
    logic [NREQ-1:0] exp_ack;

    // Stimulus state
    logic [NREQ-1:0] req_cont;
    logic [NREQ-1:0] ack_seen;
    logic            rand_mode;
    int              ack_log[$];
    int              ack_cyc[$];

    // A grant at edge e means: strobes after e, ack after e+1, free at e+3.
    task automatic model_edge();
        int off;
        int g;
        if (rst) begin
            ptr        = 0;
            last_grant = -100;
            exp_rdata  = '0;
            exp_addr   = '0;
            exp_din    = '0;
        end else if (cyc - last_grant >= 3 && bus.req != '0) begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && bus.req[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            last_grant = cyc;
            cur_g      = g;
            cur_we     = bus.we[g];
            exp_addr   = bus.addr[g * AW +: AW];
            exp_din    = bus.wdata[g * DW +: DW];
            if (cur_we) ref_mem[exp_addr] = exp_din;
            else        cur_rdv = ref_mem[exp_addr];
        end else if (cyc - last_grant == 1) begin
            if (!cur_we) exp_rdata = cur_rdv;
            ptr = (cur_g + 1) % NREQ;
        end
        off      = cyc - last_grant;
        exp_rd   = (off == 0) && !cur_we;
        exp_wr   = (off == 0) && cur_we;
        exp_ack  = (off == 1) ? (NREQ'(1) << cur_g) : '0;
        exp_busy = (off == 0) || (off == 1);
    endtask

    task automatic check_outputs();
        check_eq("ack",      32'(bus.ack),   32'(exp_ack));
        check_eq("busy",     32'(bus.busy),  32'(exp_busy));
        check_eq("ram_rd",   32'(ram_rd),    32'(exp_rd));
        check_eq("ram_wr",   32'(ram_wr),    32'(exp_wr));
        check_eq("rdata",    32'(bus.rdata), 32'(exp_rdata));
        check_eq("ram_addr", 32'(ram_addr),  32'(exp_addr));
        check_eq("ram_din",  32'(ram_din),   32'(exp_din));
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) begin
                ack_log.push_back(i);
                ack_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic new_txn(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]           = 1'b1;
        bus.we[i]            = w;
        bus.addr[i*AW +: AW] = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic new_rand_txn(input int i);
        new_txn(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 16'($urandom()));
    endtask

    // Requesters hold until the ack cycle has ended, then drop or reissue.
    task automatic drive_next();
        for (int i = 0; i < NREQ; i++) begin
            if (ack_seen[i]) begin
                if (req_cont[i] || (rand_mode && $urandom_range(0, 2) == 0)) new_rand_txn(i);
                else bus.req[i] = 1'b0;
            end else if (rand_mode && !bus.req[i] && $urandom_range(0, 3) == 0) begin
                new_rand_txn(i);
            end
        end
        ack_seen = bus.ack;
        if (rand_mode) rst = ($urandom_range(0, 149) == 0);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_outputs();
        drive_next();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_log(input string tag, input int idx, input int expv);
        if (ack_log.size() > idx) check_eq(tag, 32'(ack_log[idx]), 32'(expv));
        else                      check_eq({tag, "_missing"}, 32'(ack_log.size()), 32'(idx + 1));
    endtask

    initial begin
        logic got;
        rst        = 1'b1;
        ram_init   = 1'b1;
        bus.req    = '0;
        bus.we     = '0;
        bus.addr   = '0;
        bus.wdata  = '0;
        req_cont   = '0;
        ack_seen   = '0;
        rand_mode  = 1'b0;
        cyc        = 0;
        ptr        = 0;
        last_grant = -100;
        cur_g      = 0;
        cur_we     = 1'b0;
        cur_rdv    = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);

        // Reset state
        repeat (3) step();
        check_eq("reset_busy",  32'(bus.busy),  32'd0);
        check_eq("reset_rdata", 32'(bus.rdata), 32'd0);
        ram_init = 1'b0;
        rst      = 1'b0;

        // Single read of the preloaded word by requester 1
        new_txn(1, 1'b0, 8'h10, 16'h0000);
        got = 1'b0;
        repeat (5) begin
            step();
            if (bus.ack == 4'b0010) begin
                check_eq("single_rd_data", 32'(bus.rdata), 32'hBEEF);
                got = 1'b1;
            end
        end
        check_eq("single_rd_acked", 32'(got), 32'd1);

        // Write then read back by requester 0
        new_txn(0, 1'b1, 8'hFF, 16'h1234);
        repeat (4) step();
        new_txn(0, 1'b0, 8'hFF, 16'h0000);
        got = 1'b0;
        repeat (4) begin
            step();
            if (bus.ack == 4'b0001) begin
                check_eq("wr_rd_data", 32'(bus.rdata), 32'h1234);
                got = 1'b1;
            end
        end
        check_eq("wr_rd_acked", 32'(got), 32'd1);

        // Round-robin with all requesters asserting continuously
        do_reset();
        ack_log.delete();
        ack_cyc.delete();
        req_cont = '1;
        for (int i = 0; i < NREQ; i++) new_txn(i, 1'b0, 8'(8'h20 + i), 16'h0);
        repeat (16) step();
        req_cont = '0;
        check_log("rr_0", 0, 0);
        check_log("rr_1", 1, 1);
        check_log("rr_2", 2, 2);
        check_log("rr_3", 3, 3);
        check_log("rr_4", 4, 0);
        for (int k = 1; k < 5 && k < ack_cyc.size(); k++)
            check_eq("rr_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
        repeat (15) step();

        // Priority rotation
        do_reset();
        new_txn(2, 1'b0, 8'h30, 16'h0);
        repeat (4) step();
        ack_log.delete();
        new_txn(2, 1'b0, 8'h31, 16'h0);
        new_txn(3, 1'b0, 8'h32, 16'h0);
        repeat (7) step();
        check_log("prio_first",  0, 3);
        check_log("prio_second", 1, 2);
        new_txn(3, 1'b0, 8'h33, 16'h0);
        repeat (4) step();
        ack_log.delete();
        new_txn(2, 1'b0, 8'h34, 16'h0);
        repeat (4) step();
        check_log("prio_ptr0", 0, 2);

        // Reset in the DONE cycle of a write, then read it back
        new_txn(0, 1'b1, 8'h40, 16'hC0DE);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_done_ack",  32'(bus.ack),  32'd0);
        check_eq("rst_done_addr", 32'(ram_addr), 32'd0);
        new_txn(1, 1'b0, 8'h40, 16'h0);
        got = 1'b0;
        repeat (4) begin
            step();
            if (bus.ack == 4'b0010) begin
                check_eq("rst_rdback", 32'(bus.rdata), 32'hC0DE);
                got = 1'b1;
            end
        end
        check_eq("rst_rdback_acked", 32'(got), 32'd1);

        // Reset during ACCESS aborts without ack; held request is retried
        ack_log.delete();
        new_txn(2, 1'b1, 8'h41, 16'h5A5A);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_access_noack", 32'(ack_log.size()), 32'd0);
        repeat (5) step();
        check_log("rst_retry", 0, 2);

        // Idle stability
        repeat (20) step();

        // Randomized traffic with occasional resets
        rand_mode = 1'b1;
        repeat (600) step();
        rand_mode = 1'b0;
        rst       = 1'b0;
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
